// File: rtl/rtc_spi_ctrl.sv
// SPI master (mode 0, MSB first) for the RTC/aux header, with DATA/CTRL/DIV/PINS registers.
// Optional feature macro: RTC_SPI_IRQ_EN adds the ie bit and the level transfer-complete irq.
module rtc_spi_ctrl #(
  parameter logic [7:0] DIV_RESET = 8'd3
) (
  input  logic       phi2,
  input  logic       reset_n,
  input  logic       bus_we,
  input  logic [2:0] bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs,
  output logic       irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_hc;
  logic [7:0] r_shift;
  logic [7:0] r_rx;
  logic [7:0] r_div;
  logic [2:0] r_bit;
  logic       r_sck;
  logic       r_mosi;
  logic       r_cs;
  logic       r_ovr;
  logic       r_done;
  logic       w_ie;
  logic       w_busy;
  logic       w_wrData;
  logic       w_wrCtrl;
  logic       w_wrDiv;
  logic       w_start;
  logic       w_hcHit;
  logic       w_rise;
  logic       w_fall;

  assign w_busy   = (r_state != ST_IDLE);
  assign w_wrData = bus_we && (bus_addr == 3'd0);
  assign w_wrCtrl = bus_we && (bus_addr == 3'd1);
  assign w_wrDiv  = bus_we && (bus_addr == 3'd2);
  assign w_start  = w_wrData && !w_busy;
  assign w_hcHit  = (r_hc == r_div);

  always_ff @(posedge phi2 or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_rise = 1'b0;
    w_fall = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start) w_next = ST_LO;
      ST_LO: begin
        if (w_hcHit) begin
          w_rise = 1'b1;
          w_next = ST_HI;
        end
      end
      ST_HI: begin
        if (w_hcHit) begin
          w_fall = 1'b1;
          w_next = (r_bit == 3'd7) ? ST_IDLE : ST_LO;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Half-period counter restarts on every state entry and idles at zero.
  always_ff @(posedge phi2 or negedge reset_n) begin
    if (!reset_n)                                     r_hc <= 8'd0;
    else if ((w_next != r_state) || !w_busy)          r_hc <= 8'd0;
    else                                              r_hc <= r_hc + 8'd1;
  end

  always_ff @(posedge phi2 or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= 8'd0;
      r_rx    <= 8'd0;
      r_bit   <= 3'd0;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_start) begin
        r_shift <= bus_wdata;
        r_mosi  <= bus_wdata[7];
        r_bit   <= 3'd0;
        r_done  <= 1'b0;
      end
      if (w_rise) begin
        r_sck   <= 1'b1;
        r_shift <= {r_shift[6:0], spi_miso};
      end
      if (w_fall) begin
        r_sck <= 1'b0;
        if (r_bit == 3'd7) begin
          r_rx   <= r_shift;
          r_done <= 1'b1;
        end else begin
          r_bit  <= r_bit + 3'd1;
          r_mosi <= r_shift[7];
        end
      end
    end
  end

  // Writes that land mid-transfer are dropped and flagged; clearing ovr beats a same-cycle set.
  always_ff @(posedge phi2 or negedge reset_n) begin
    if (!reset_n) begin
      r_ovr <= 1'b0;
      r_cs  <= 1'b0;
      r_div <= DIV_RESET;
    end else begin
      if (w_wrCtrl && bus_wdata[2])
        r_ovr <= 1'b0;
      else if (w_busy && (w_wrData || w_wrCtrl || w_wrDiv))
        r_ovr <= 1'b1;
      if (w_wrCtrl && !w_busy) r_cs  <= bus_wdata[1];
      if (w_wrDiv && !w_busy)  r_div <= bus_wdata;
    end
  end

`ifdef RTC_SPI_IRQ_EN
  logic r_ie;

  always_ff @(posedge phi2 or negedge reset_n) begin
    if (!reset_n)                  r_ie <= 1'b0;
    else if (w_wrCtrl && !w_busy)  r_ie <= bus_wdata[4];
  end

  assign w_ie = r_ie;
  assign irq  = r_done & r_ie;
`else
  assign w_ie = 1'b0;
  assign irq  = 1'b0;
`endif

  always_comb begin
    bus_rdata = 8'h00;
    case (bus_addr)
      3'd0:    bus_rdata = r_rx;
      3'd1:    bus_rdata = {3'b000, w_ie, r_done, r_ovr, r_cs, w_busy};
      3'd2:    bus_rdata = r_div;
      3'd3:    bus_rdata = {4'b0000, r_cs, r_mosi, spi_miso, r_sck};
      default: bus_rdata = 8'h00;
    endcase
  end

  assign spi_sck  = r_sck;
  assign spi_mosi = r_mosi;
  assign spi_cs   = r_cs;

endmodule
